// File: rtl/hazard_ctrl_pkg.sv
// Purpose : shared pipeline constants for the hazard controller (FSM encoding, NOP word).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // FSM encoding; kept as plain 2-bit constants so older tools and netlists
  // that grep for the raw state values keep working.
  localparam logic [1:0] ST_RUN         = 2'd0;  // normal flow
  localparam logic [1:0] ST_IMISS       = 2'd1;  // fetch outstanding
  localparam logic [1:0] ST_IMISS_REDIR = 2'd2;  // outstanding fetch is wrong-path

  // addi x0, x0, 0 -- the canonical NOP loaded into IF/ID on a flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Purpose : flags a load in EX whose destination feeds a source of the instruction in ID.
// Latency : pure combinational, zero cycles.
// Backpr. : none; consumed by the hazard FSM in the same cycle.
//
// Ports: ID_rs1_i/ID_rs2_i  source fields of the ID instruction
//        EX_rd_i            destination of the EX instruction
//        EX_MemRead_i       EX instruction is a load
//        lu_o               load-use hazard present
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ID_rs1_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_i,
  input  logic [REG_ADDR_W-1:0] EX_rd_i,
  input  logic                  EX_MemRead_i,
  output logic                  lu_o
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_o = EX_MemRead_i && (EX_rd_i != '0) &&
                ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard controller -- load-use stall, branch flush, I-miss handling, stall counter.
// Latency : outputs combinational from state + current inputs (zero cycles); state/counter update on posedge.
// Backpr. : stalls PC (PC_Write=0) on load-use and while a fetch is outstanding; counter saturates.
//
// Ports: clk, reset (sync, active-low)
//        ID_rs1/ID_rs2/EX_rd/EX_MemRead  operand/load info for hazard detection
//        branch_taken, imem_valid        redirect and fetch-ready events
//        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble  pipeline controls
//        stall_cycles                    saturating count of cycles with PC_Write=0
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  ID_rs1,
  input  logic [REG_ADDR_W-1:0]  ID_rs2,
  input  logic [REG_ADDR_W-1:0]  EX_rd,
  input  logic                   EX_MemRead,
  input  logic                   branch_taken,
  input  logic                   imem_valid,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [1:0]             state_q, state_d, state_eff;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   lu;

  load_use_detect u_lu (
    .ID_rs1_i     (ID_rs1),
    .ID_rs2_i     (ID_rs2),
    .EX_rd_i      (EX_rd),
    .EX_MemRead_i (EX_MemRead),
    .lu_o         (lu)
  );

  // While reset is asserted the outputs follow the RUN rules even if the
  // register still holds a miss state; the next edge clears it anyway.
  assign state_eff = reset ? state_q : ST_RUN;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    state_d      = ST_RUN;

    if (state_eff == ST_IMISS_REDIR) begin
      // The word in flight is wrong-path: keep flushing it and hold the PC
      // unless a new redirect arrives. A load-use hold on IF/ID wins over the
      // flush, since flushing a register that is not loaded is meaningless.
      PC_Write     = branch_taken;
      IF_ID_Write  = !lu;
      IF_ID_Flush  = !lu;
      ID_EX_Bubble = branch_taken || lu;
      state_d      = imem_valid ? ST_RUN : ST_IMISS_REDIR;
    end else begin
      // RUN and IMISS share output rules.
      if (branch_taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (lu) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (!imem_valid) begin
        PC_Write     = 1'b0;
        IF_ID_Flush  = 1'b1;
      end

      if (state_eff == ST_IMISS) begin
        // A redirect during an outstanding fetch makes that fetch wrong-path.
        if (imem_valid)        state_d = ST_RUN;
        else if (branch_taken) state_d = ST_IMISS_REDIR;
        else                   state_d = ST_IMISS;
      end else if (!branch_taken && !lu && !imem_valid) begin
        state_d = ST_IMISS;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset, synchronous, active-low (0 = reset, sampled on posedge clk).
REQ-004 ID_rs1  in  5  rs1 field of the instruction in ID.
REQ-005 ID_rs2  in  5  rs2 field of the instruction in ID.
REQ-006 EX_rd  in  5  destination register of the instruction in EX.
REQ-007 EX_MemRead  in  1  instruction in EX is a load.
REQ-008 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 imem_valid  in  1  instruction memory presents a valid fetch word this cycle.
REQ-010 PC_Write  out  1  PC register load enable.
REQ-011 IF_ID_Write  out  1  IF/ID register load enable.
REQ-012 IF_ID_Flush  out  1  load a NOP (32'h00000013) into IF/ID instead of the fetched word.
REQ-013 ID_EX_Bubble  out  1  zero all control fields entering ID/EX.
REQ-014 stall_cycles  out  STALL_CNT_W  count of cycles with PC_Write=0.

Function
REQ-015 Load-use condition lu SHALL be EX_MemRead & (EX_rd!=0) & ((EX_rd==ID_rs1) | (EX_rd==ID_rs2)).
REQ-016 FSM states SHALL be RUN, IMISS (fetch outstanding) and IMISS_REDIR (outstanding fetch is wrong-path).
REQ-017 Outputs SHALL be combinational from state and current inputs; there is zero cycle latency from input to output.
REQ-018 RUN, priority branch_taken > lu > !imem_valid.
REQ-019 RUN+branch_taken: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1; next RUN; lu and imem_valid are ignored.
REQ-020 RUN+lu: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1; next RUN irrespective of imem_valid.
REQ-021 RUN+!imem_valid: PC_Write=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0; next IMISS.
REQ-022 RUN, no event: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-023 IMISS: identical output rules to RUN, with these next-state rules:
  - branch_taken with imem_valid=0: next IMISS_REDIR.
  - branch_taken with imem_valid=1: next RUN.
  - lu: stay IMISS if imem_valid=0, else RUN.
  - otherwise: next RUN on imem_valid=1, else stay IMISS.
REQ-024 IMISS_REDIR outputs: PC_Write=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=(branch_taken|lu).
  - lu also forces IF_ID_Write=0.
  - branch_taken also forces PC_Write=1.
  - Next state RUN on imem_valid=1, else stay.
REQ-025 stall_cycles SHALL increment by 1 on each posedge where PC_Write=0, and SHALL saturate at all-ones without wrapping.
REQ-026 IF_ID_Flush=1 SHALL never coincide with IF_ID_Write=0.

Reset
REQ-027 While reset=0 at posedge clk, state SHALL go to RUN and stall_cycles SHALL go to 0, regardless of any other input, including mid-miss.
REQ-028 During reset, outputs SHALL follow the RUN rules combinationally; downstream registers are held in reset by their own reset inputs.

Structure
REQ-029 State encoding (RUN=2'd0, IMISS=2'd1, IMISS_REDIR=2'd2) and the NOP constant SHALL live in the shared pipeline package.
REQ-030 lu SHALL be computed in one sub-module, load_use_detect (pure combinational); FSM and counter SHALL stay in hazard_ctrl.

Verification
REQ-031 ID_rs1=5, EX_rd=5, EX_MemRead=1, imem_valid=1 -> same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles 0->1.
REQ-032 EX_rd=0, EX_MemRead=1, ID_rs1=0 -> no stall, all enables 1, bubble 0.
REQ-033 imem_valid=0 for 3 cycles, then 1 -> IF_ID_Flush=1 and PC_Write=0 for 3 cycles, state returns to RUN; stall_cycles=3.
REQ-034 branch_taken=1 with lu=1 in RUN -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; next cycle normal flow.
REQ-035 Sequence: imem_valid=0 (enter IMISS), branch_taken=1 with imem_valid=0, then 2 cycles imem_valid=0, then imem_valid=1.
  - Required: PC_Write=1 only in the branch cycle.
  - IF_ID_Flush=1 through the cycle imem_valid returns.
  - State then RUN.
REQ-036 Preload stall_cycles near saturation with 16 forced stalls, and reset=0 asserted mid-IMISS.
  - Required: counter holds at 16'hFFFF.
  - After reset, state is RUN and stall_cycles=0.
